sha256_digest_hex_tx: RTL

Downstream formatting stage between `sha256_processor` and `uart_tx`. On a `done` pulse it captures the 256-bit digest and serialises it as 64 ASCII hex characters, most significant nibble first. The characters go out over a valid/ready byte handshake that connects directly to `uart_tx`'s `tx_data`/`tx_data_valid`/`tx_data_ready`. An optional CR LF terminator follows the hex characters. This block replaces the ad-hoc SEND/DONE logic of the top-level controller.

---
 rtl/sha256_digest_hex_tx.sv | 94 +++++++++
 1 files changed

// File: rtl/sha256_digest_hex_tx.sv
// sha256_digest_hex_tx: captures a 256-bit digest and streams it as 64 ASCII hex chars (+ optional CR LF) over valid/ready
//   clk, rst                      : clock, synchronous active-high reset
//   digest_in, digest_valid       : digest and its one-cycle capture strobe
//   busy, overrun, frame_done     : frame in progress, dropped-digest pulse, end-of-frame pulse
//   tx_data, tx_data_valid/ready  : byte stream toward uart_tx
module sha256_digest_hex_tx #(
  parameter bit UPPERCASE   = 1'b0,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] digest_in,
  input  logic         digest_valid,
  output logic         busy,
  output logic         overrun,
  output logic         frame_done,
  output logic [7:0]   tx_data,
  output logic         tx_data_valid,
  input  logic         tx_data_ready
);
  typedef enum logic [1:0] {IDLE, HEX, CR, LF} state_t;
  state_t state, state_n;
  logic [255:0] sr, sr_n;
  logic [5:0] idx, idx_n;
  logic [7:0] data_n;
  logic valid_n, xfer, last, cap, drop;
  function automatic logic [7:0] asc(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'd0, n} : (UPPERCASE ? 8'h41 : 8'h61) + {4'd0, n} - 8'd10;
  endfunction
  always_comb begin
    xfer = tx_data_valid && tx_data_ready;
    last = xfer && (state == LF || (state == HEX && idx == 6'd63 && !APPEND_CRLF));
    // capture on the final transfer too, so frames chain without an idle gap
    cap = digest_valid && (state == IDLE || last);
    drop = digest_valid && !cap;
    state_n = state;
    sr_n = sr;
    idx_n = idx;
    data_n = tx_data;
    valid_n = tx_data_valid;
    if (xfer)
      case (state)
        HEX:
          if (idx != 6'd63) begin
            sr_n = sr << 4;
            idx_n = idx + 6'd1;
            data_n = asc(sr[251:248]);
          end else if (APPEND_CRLF) begin
            data_n = 8'h0d;
            state_n = CR;
          end else begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        CR: begin
          data_n = 8'h0a;
          state_n = LF;
        end
        LF: begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
        default: ;
      endcase
    if (cap) begin
      sr_n = digest_in;
      idx_n = 6'd0;
      data_n = asc(digest_in[255:252]);
      valid_n = 1'b1;
      state_n = HEX;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      idx <= '0;
      tx_data <= 8'h00;
      tx_data_valid <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      idx <= idx_n;
      tx_data <= data_n;
      tx_data_valid <= valid_n;
      busy <= state_n != IDLE;
      overrun <= drop;
      frame_done <= last;
    end
  end
endmodule
